time_set_controller: RTL and testbench

TIME_SET_CONTROLLER -- requirements
Module: time_set_controller

---
 rtl/time_set_controller.sv | 168 ++++++++++++++++
 tb/tb_time_set_controller.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/time_set_controller.sv
// Clock time-set controller: RUN -> SET_HR -> SET_MIN mode sequencing, hold-to-repeat
// increment pulses, digit blink mask and idle timeout back to RUN.
module time_set_controller #(
    parameter int HOLD_CYCLES    = 50000000,
    parameter int REPEAT_CYCLES  = 10000000,
    parameter int BLINK_CYCLES   = 25000000,
    parameter int TIMEOUT_CYCLES = 1000000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_mode,
    input  logic       btn_up,
    input  logic       sw_en,
    output logic       run_en,
    output logic       hrup,
    output logic       minup,
    output logic [3:0] blank,
    output logic [1:0] mode
);

    localparam int HMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int HW   = $clog2(HMAX + 1);
    localparam int BW   = $clog2(BLINK_CYCLES + 1);
    localparam int IW   = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        RUN     = 2'b00,
        SET_HR  = 2'b01,
        SET_MIN = 2'b10
    } state_e;

    state_e          state_q, state_d;
    logic            mode_prev_q, up_prev_q;
    logic [HW-1:0]   hold_q, hold_d, hold_inc;
    logic            armed_q, armed_d;
    logic            rpt_q, rpt_d;
    logic [BW-1:0]   blink_q, blink_d;
    logic            phase_q, phase_d;
    logic [IW-1:0]   idle_q, idle_d, idle_inc;
    logic            run_en_q, run_en_d;
    logic            hrup_q, hrup_d;
    logic            minup_q, minup_d;
    logic [3:0]      blank_q, blank_d;
    logic            mode_ev, up_ev, pulse;

    assign mode_ev  = btn_mode & ~mode_prev_q;
    assign up_ev    = btn_up & ~up_prev_q;
    assign hold_inc = hold_q + HW'(1);
    assign idle_inc = idle_q + IW'(1);

    always_comb begin
        state_d = state_q;
        hold_d  = '0;
        armed_d = 1'b0;
        rpt_d   = 1'b0;
        blink_d = '0;
        phase_d = 1'b0;
        idle_d  = '0;
        pulse   = 1'b0;

        case (state_q)
            RUN: begin
                if (mode_ev) state_d = SET_HR;
            end
            SET_HR, SET_MIN: begin
                if (mode_ev) begin
                    state_d = (state_q == SET_HR) ? SET_MIN : RUN;
                end else begin
                    // armed only after a genuine press in this mode, so a level held
                    // across a mode change or reset never starts auto-repeat
                    if (up_ev) begin
                        pulse   = 1'b1;
                        armed_d = 1'b1;
                    end else if (btn_up && armed_q) begin
                        armed_d = 1'b1;
                        rpt_d   = rpt_q;
                        hold_d  = hold_inc;
                        if (hold_inc == HW'(rpt_q ? REPEAT_CYCLES : HOLD_CYCLES)) begin
                            pulse  = 1'b1;
                            hold_d = '0;
                            rpt_d  = 1'b1;
                        end
                    end

                    if (pulse) begin
                        blink_d = '0;
                        phase_d = 1'b0;
                    end else if (blink_q == BW'(BLINK_CYCLES - 1)) begin
                        blink_d = '0;
                        phase_d = ~phase_q;
                    end else begin
                        blink_d = blink_q + BW'(1);
                        phase_d = phase_q;
                    end

                    if (up_ev || pulse) begin
                        idle_d = '0;
                    end else if (idle_inc == IW'(TIMEOUT_CYCLES)) begin
                        state_d = RUN;
                    end else begin
                        idle_d = idle_inc;
                    end
                end
            end
            default: state_d = RUN;
        endcase

        // any state change starts the new mode from a clean slate
        if (state_d != state_q) begin
            hold_d  = '0;
            armed_d = 1'b0;
            rpt_d   = 1'b0;
            blink_d = '0;
            phase_d = 1'b0;
            idle_d  = '0;
            pulse   = 1'b0;
        end

        run_en_d = (state_d == RUN) ? sw_en : 1'b0;
        hrup_d   = pulse && (state_q == SET_HR);
        minup_d  = pulse && (state_q == SET_MIN);

        blank_d = 4'b0000;
        if (phase_d && !btn_up) begin
            if (state_d == SET_HR)  blank_d = 4'b1100;
            if (state_d == SET_MIN) blank_d = 4'b0011;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= RUN;
            mode_prev_q <= 1'b0;
            up_prev_q   <= 1'b0;
            hold_q      <= '0;
            armed_q     <= 1'b0;
            rpt_q       <= 1'b0;
            blink_q     <= '0;
            phase_q     <= 1'b0;
            idle_q      <= '0;
            run_en_q    <= 1'b0;
            hrup_q      <= 1'b0;
            minup_q     <= 1'b0;
            blank_q     <= 4'b0000;
        end else begin
            state_q     <= state_d;
            mode_prev_q <= btn_mode;
            up_prev_q   <= btn_up;
            hold_q      <= hold_d;
            armed_q     <= armed_d;
            rpt_q       <= rpt_d;
            blink_q     <= blink_d;
            phase_q     <= phase_d;
            idle_q      <= idle_d;
            run_en_q    <= run_en_d;
            hrup_q      <= hrup_d;
            minup_q     <= minup_d;
            blank_q     <= blank_d;
        end
    end

    assign mode   = state_q;
    assign run_en = run_en_q;
    assign hrup   = hrup_q;
    assign minup  = minup_q;
    assign blank  = blank_q;

endmodule

// File: tb/tb_time_set_controller.sv
// Scoreboard bench for time_set_controller: a timing model of the set-mode behaviour
// queues expected outputs per driven cycle, compared after each rising edge.
module tb_time_set_controller;

    localparam int HOLD  = 8;
    localparam int REP   = 4;
    localparam int BLINK = 3;
    localparam int TMO   = 40;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_mode = 1'b0, btn_up = 1'b0, sw_en = 1'b0;
    logic       run_en, hrup, minup;
    logic [3:0] blank;
    logic [1:0] mode;

    always #5 clk = ~clk;

    time_set_controller #(
        .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP),
        .BLINK_CYCLES(BLINK), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .rst(rst), .btn_mode(btn_mode), .btn_up(btn_up), .sw_en(sw_en),
        .run_en(run_en), .hrup(hrup), .minup(minup), .blank(blank), .mode(mode)
    );

    typedef struct packed {
        logic [1:0] mode;
        logic       run_en;
        logic       hrup;
        logic       minup;
        logic [3:0] blank;
    } exp_t;

    exp_t sbq[$];
    int n_chk = 0, n_pass = 0;
    int hr_cnt = 0, min_cnt = 0;
    // model state: cycles since press (-1 = not armed), since phase reference, idle
    int m_mode, m_pm, m_pu, m_since, m_ph, m_idle;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_mode"}, mode, 0);
        chk({tag, "_run_en"}, run_en, 0);
        chk({tag, "_hrup"}, hrup, 0);
        chk({tag, "_minup"}, minup, 0);
        chk({tag, "_blank"}, blank, 0);
    endtask

    task automatic model_reset();
        m_mode = 0; m_pm = 0; m_pu = 0; m_since = -1; m_ph = 0; m_idle = 0;
    endtask

    task automatic model_step(input logic bm, input logic bu, input logic sw);
        exp_t e;
        bit mev, uev, pulse;
        int nm;
        mev = bm && (m_pm == 0);
        uev = bu && (m_pu == 0);
        pulse = 0;
        nm = m_mode;
        if (m_mode == 0) begin
            if (mev) nm = 1;
        end else if (mev) begin
            nm = (m_mode == 1) ? 2 : 0;
        end else begin
            if (uev) begin
                pulse = 1; m_since = 0;
            end else if (bu && m_since >= 0) begin
                m_since++;
                if (m_since == HOLD || (m_since > HOLD && (m_since - HOLD) % REP == 0)) pulse = 1;
            end else begin
                m_since = -1;
            end
            m_ph   = pulse ? 0 : m_ph + 1;
            m_idle = (uev || pulse) ? 0 : m_idle + 1;
            if (m_idle == TMO) nm = 0;
        end
        if (nm != m_mode) begin
            m_since = -1; m_ph = 0; m_idle = 0; pulse = 0;
        end
        e.mode   = nm[1:0];
        e.run_en = (nm == 0) ? sw : 1'b0;
        e.hrup   = pulse && (m_mode == 1);
        e.minup  = pulse && (m_mode == 2);
        if (nm != 0 && ((m_ph / BLINK) % 2 == 1) && !bu)
            e.blank = (nm == 1) ? 4'b1100 : 4'b0011;
        else
            e.blank = 4'b0000;
        m_mode = nm; m_pm = bm; m_pu = bu;
        sbq.push_back(e);
    endtask

    task automatic tick(input logic bm, input logic bu, input logic sw);
        exp_t e;
        btn_mode = bm; btn_up = bu; sw_en = sw;
        model_step(bm, bu, sw);
        @(posedge clk); #1;
        if (sbq.size() == 0) begin
            chk("sb_empty", 0, 1);
        end else begin
            e = sbq.pop_front();
            chk("mode", mode, e.mode);
            chk("run_en", run_en, e.run_en);
            chk("hrup", hrup, e.hrup);
            chk("minup", minup, e.minup);
            chk("blank", blank, e.blank);
        end
        hr_cnt  += int'(hrup);
        min_cnt += int'(minup);
    endtask

    task automatic press_mode(input logic sw);
        tick(1'b1, 1'b0, sw);
        tick(1'b0, 1'b0, sw);
    endtask

    initial begin
        logic hold_up, sw;
        model_reset();
        #12;
        chk_zero("rst_init");
        @(posedge clk); #1;
        chk_zero("rst_held");
        #3 rst = 1'b0;

        // run_en follows sw_en from the first edge after release
        tick(1'b0, 1'b0, 1'b1);
        chk("rel_run_en", run_en, 1);
        tick(1'b0, 1'b0, 1'b1);

        // three mode presses
        tick(1'b1, 1'b0, 1'b1);
        chk("p1_mode", mode, 2'b01); chk("p1_run_en", run_en, 0);
        tick(1'b0, 1'b0, 1'b1);
        tick(1'b1, 1'b0, 1'b1);
        chk("p2_mode", mode, 2'b10); chk("p2_run_en", run_en, 0);
        tick(1'b0, 1'b0, 1'b1);
        tick(1'b1, 1'b0, 1'b1);
        chk("p3_mode", mode, 2'b00); chk("p3_run_en", run_en, 1);
        tick(1'b0, 1'b0, 1'b1);

        // SET_HR: hold btn_up for 20 cycles
        press_mode(1'b1);
        hr_cnt = 0; min_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1'b0, 1'b1, 1'b1);
            if (i == 0) chk("hold_first_hrup", hrup, 1);
        end
        tick(1'b0, 1'b0, 1'b1);
        chk("hold_hr_pulses", hr_cnt, 4);
        chk("hold_min_pulses", min_cnt, 0);

        // simultaneous mode and up press in SET_HR
        hr_cnt = 0; min_cnt = 0;
        tick(1'b1, 1'b1, 1'b1);
        chk("simul_mode", mode, 2'b10);
        tick(1'b0, 1'b1, 1'b1);
        tick(1'b0, 1'b1, 1'b1);
        tick(1'b0, 1'b0, 1'b1);
        chk("simul_pulses", hr_cnt + min_cnt, 0);

        // SET_MIN idle: blink then timeout
        for (int i = 0; i < 45; i++) tick(1'b0, 1'b0, 1'b1);
        chk("tmo_mode", mode, 2'b00);
        chk("tmo_blank", blank, 4'b0000);

        // RUN: btn_up ignored, run_en tracks sw_en
        hr_cnt = 0; min_cnt = 0;
        for (int i = 0; i < 8; i++) tick(1'b0, 1'(i % 2), 1'(i % 3 != 0));
        chk("run_pulses", hr_cnt + min_cnt, 0);

        // reset mid-hold in SET_MIN
        press_mode(1'b1);
        press_mode(1'b1);
        for (int i = 0; i < 5; i++) tick(1'b0, 1'b1, 1'b1);
        #3 rst = 1'b1;
        #1 chk_zero("async_rst");
        model_reset();
        @(posedge clk); #1;
        chk_zero("rst_mid");
        #2 rst = 1'b0;
        hr_cnt = 0; min_cnt = 0;
        for (int i = 0; i < 12; i++) tick(1'b0, 1'b1, 1'b1);
        chk("post_rst_pulses", hr_cnt + min_cnt, 0);
        tick(1'b0, 1'b0, 1'b1);

        // random traffic
        hold_up = 1'b0; sw = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 11) == 0) hold_up = ~hold_up;
            if ($urandom_range(0, 19) == 0) sw = ~sw;
            tick(1'($urandom_range(0, 14) == 0), hold_up, sw);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
